// File: rtl/exe_stage.sv
// exe_stage: execute stage with operand forwarding, ALU, branch resolution and EXE/MEM register.
// Define ITER_MUL_EN to add the iterative shift-add multiplier that stalls upstream while busy.
module exe_stage #(
    parameter int W     = 32,
    parameter int MUL_N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] val1,
    input  logic [W-1:0] val2,
    input  logic [W-1:0] reg2,
    input  logic [W-1:0] PC_in,
    input  logic [1:0]   Br_type,
    input  logic [3:0]   exe_cmd,
    input  logic         mem_r_en,
    input  logic         mem_w_en,
    input  logic         wb_en,
    input  logic [4:0]   dst,
    input  logic [1:0]   fwd_a,
    input  logic [1:0]   fwd_b,
    input  logic [1:0]   fwd_s,
    input  logic [W-1:0] mem_fwd,
    input  logic [W-1:0] wb_fwd,
    input  logic         memReady,
    output logic [W-1:0] alu_res,
    output logic [W-1:0] st_val,
    output logic [4:0]   dst_out,
    output logic         mem_r_en_out,
    output logic         mem_w_en_out,
    output logic         wb_en_out,
    output logic         br_taken,
    output logic [W-1:0] br_addr,
    output logic         exe_stall
);
    localparam logic [3:0] CMD_MUL = 4'b1100;
    logic [W-1:0] a, b, s, alu, mul_res;
    logic [W-1:0] alu_res_q, st_val_q;
    logic [4:0]   dst_q;
    logic [2:0]   ctl_q;
    always_comb begin
        a = fwd_a == 2'b01 ? mem_fwd : fwd_a == 2'b10 ? wb_fwd : val1;
        b = fwd_b == 2'b01 ? mem_fwd : fwd_b == 2'b10 ? wb_fwd : val2;
        s = fwd_s == 2'b01 ? mem_fwd : fwd_s == 2'b10 ? wb_fwd : reg2;
    end
    always_comb begin
        alu = '0;
        case (exe_cmd)
            4'b0000: alu = a + b;
            4'b0010: alu = a - b;
            4'b0100: alu = a & b;
            4'b0101: alu = a | b;
            4'b0110: alu = ~(a | b);
            4'b0111: alu = a ^ b;
            4'b1000: alu = a << b[4:0];
            4'b1001: alu = a >> b[4:0];
            4'b1010: alu = $signed(a) >>> b[4:0];
            CMD_MUL: alu = mul_res;
            default: alu = '0;
        endcase
    end
`ifdef ITER_MUL_EN
    localparam int CW = $clog2(MUL_N + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (exe_cmd == CMD_MUL) begin
                state_d  = RUN;
                mcand_d  = a;
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
            end
            RUN: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = cnt_q == CW'(MUL_N - 1) ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end
    // memReady freezes the multiplier along with the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (memReady) begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
    assign mul_res   = acc_q;
    assign exe_stall = !rst && ((state_q == IDLE && exe_cmd == CMD_MUL) || state_q == RUN);
`else
    assign mul_res   = '0;
    assign exe_stall = 1'b0;
`endif
    assign br_taken = !exe_stall && (Br_type == 2'b01 ? a == '0 : Br_type == 2'b10 ? a != s : Br_type == 2'b11);
    assign br_addr  = PC_in + (b << 2);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {alu_res_q, st_val_q, dst_q, ctl_q} <= '0;
        end else if (memReady) begin
            {alu_res_q, st_val_q, dst_q, ctl_q} <= exe_stall ? '0 : {alu, s, dst, mem_r_en, mem_w_en, wb_en};
        end
    end
    assign alu_res = alu_res_q;
    assign st_val  = st_val_q;
    assign dst_out = dst_q;
    assign {mem_r_en_out, mem_w_en_out, wb_en_out} = ctl_q;
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed vectors checked against a behavioural model every cycle plus literal expectations.
module tb_exe_stage;
    localparam int MUL_N = 32;
    logic        clk = 0;
    logic        rst;
    logic [31:0] val1, val2, reg2, PC_in, mem_fwd, wb_fwd;
    logic [1:0]  Br_type, fwd_a, fwd_b, fwd_s;
    logic [3:0]  exe_cmd;
    logic        mem_r_en, mem_w_en, wb_en, memReady;
    logic [4:0]  dst;
    logic [31:0] alu_res, st_val, br_addr;
    logic [4:0]  dst_out;
    logic        mem_r_en_out, mem_w_en_out, wb_en_out, br_taken, exe_stall;

    exe_stage dut (
        .clk(clk), .rst(rst), .val1(val1), .val2(val2), .reg2(reg2), .PC_in(PC_in),
        .Br_type(Br_type), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en(wb_en), .dst(dst), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_s(fwd_s),
        .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .memReady(memReady), .alu_res(alu_res),
        .st_val(st_val), .dst_out(dst_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .wb_en_out(wb_en_out), .br_taken(br_taken),
        .br_addr(br_addr), .exe_stall(exe_stall)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: k counts productive cycles spent on the current MUL; the product appears at k == MUL_N+1
    logic [31:0] m_alu, m_st, mul_a, mul_b;
    logic [4:0]  m_dst;
    logic [2:0]  m_ctl;
    int          k;

    function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] v);
        return f == 2'd1 ? mem_fwd : f == 2'd2 ? wb_fwd : v;
    endfunction

    function automatic logic m_stall();
`ifdef ITER_MUL_EN
        return !rst && exe_cmd == 4'hC && k <= MUL_N;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_res(input logic [31:0] x, input logic [31:0] y);
        int sh;
        logic [31:0] ones;
        sh = int'(y % 32);
        ones = 32'hFFFFFFFF;
        case (exe_cmd)
            4'h0: return x + y;
            4'h2: return x + ~y + 32'd1;
            4'h4: return x & y;
            4'h5: return x | y;
            4'h6: return ~(x | y);
            4'h7: return x ^ y;
            4'h8: return x * (32'd1 << sh);
            4'h9: return x / (32'd1 << sh);
            4'hA: return (x >> sh) | (x[31] ? ~(ones >> sh) : 32'd0);
`ifdef ITER_MUL_EN
            4'hC: return k == MUL_N + 1 ? mul_a * mul_b : 32'd0;
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_alu <= '0; m_st <= '0; m_dst <= '0; m_ctl <= '0; k <= 0;
        end else if (memReady) begin
            if (m_stall()) begin
                m_alu <= '0; m_st <= '0; m_dst <= '0; m_ctl <= '0;
            end else begin
                m_alu <= m_res(pick(fwd_a, val1), pick(fwd_b, val2));
                m_st  <= pick(fwd_s, reg2);
                m_dst <= dst;
                m_ctl <= {mem_r_en, mem_w_en, wb_en};
            end
`ifdef ITER_MUL_EN
            if (exe_cmd == 4'hC) begin
                if (k == 0) begin
                    mul_a <= pick(fwd_a, val1);
                    mul_b <= pick(fwd_b, val2);
                end
                k <= k == MUL_N + 1 ? 0 : k + 1;
            end else k <= 0;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] ea, es;
            logic eb;
            ea = pick(fwd_a, val1);
            es = pick(fwd_s, reg2);
            eb = !m_stall() && ((Br_type == 2'd1 && ea == 0) || (Br_type == 2'd2 && ea != es) || Br_type == 2'd3);
            check("m_alu_res", alu_res, m_alu);
            check("m_st_val", st_val, m_st);
            check("m_dst_out", {27'd0, dst_out}, {27'd0, m_dst});
            check("m_ctl_out", {29'd0, mem_r_en_out, mem_w_en_out, wb_en_out}, {29'd0, m_ctl});
            check("m_br_taken", {31'd0, br_taken}, {31'd0, eb});
            check("m_br_addr", br_addr, PC_in + 32'd4 * pick(fwd_b, val2));
            check("m_exe_stall", {31'd0, exe_stall}, {31'd0, m_stall()});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    logic [3:0] ops [8] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    int n;

    initial begin
        rst = 1; val1 = 0; val2 = 0; reg2 = 0; PC_in = 0; mem_fwd = 0; wb_fwd = 0;
        Br_type = 0; fwd_a = 0; fwd_b = 0; fwd_s = 0; exe_cmd = 0;
        mem_r_en = 0; mem_w_en = 0; wb_en = 0; memReady = 1; dst = 0;
        step();
        rst = 0;
        chk_en = 1;
        check("reset_alu_res", alu_res, 32'd0);
        check("reset_wb_en_out", {31'd0, wb_en_out}, 32'd0);
        check("reset_exe_stall", {31'd0, exe_stall}, 32'd0);
        val1 = 5; val2 = 7; wb_en = 1; dst = 3; reg2 = 32'h55;
        step();
        check("add_alu_res", alu_res, 32'd12);
        check("add_wb_en_out", {31'd0, wb_en_out}, 32'd1);
        check("add_dst_out", {27'd0, dst_out}, 32'd3);
        exe_cmd = 4'h2; val1 = 0; val2 = 1; mem_w_en = 1;
        step();
        check("sub_wrap", alu_res, 32'hFFFFFFFF);
        exe_cmd = 4'hA; val1 = 32'h80000000; val2 = 4; mem_w_en = 0; mem_r_en = 1;
        step();
        check("sra_signfill", alu_res, 32'hF8000000);
        val1 = 32'hF0F01234; val2 = 32'h00000F13;
        foreach (ops[i]) begin
            exe_cmd = ops[i];
            step();
            if (ops[i] == 4'h7) check("xor_vec", alu_res, 32'hF0F01D27);
        end
        exe_cmd = 4'h3;
        step();
        check("undef_cmd", alu_res, 32'd0);
        exe_cmd = 4'h0; fwd_a = 1; mem_fwd = 9; val1 = 1; val2 = 1; fwd_s = 2; wb_fwd = 32'hAB; mem_r_en = 0;
        step();
        check("fwd_a_mem", alu_res, 32'd10);
        check("fwd_s_wb", st_val, 32'hAB);
        fwd_b = 2; wb_fwd = 32'h20;
        step();
        fwd_a = 0; fwd_b = 0; fwd_s = 0;
        Br_type = 2; val1 = 3; reg2 = 3;
        #1 check("bne_equal", {31'd0, br_taken}, 32'd0);
        Br_type = 1; val1 = 0; PC_in = 32'h100; val2 = 4;
        #1 check("bez_taken", {31'd0, br_taken}, 32'd1);
        check("bez_addr", br_addr, 32'h110);
        Br_type = 3; val1 = 7;
        #1 check("jmp_taken", {31'd0, br_taken}, 32'd1);
        step();
        check("add_after_br", alu_res, 32'd11);
        Br_type = 0; memReady = 0; val1 = 100; dst = 9;
        step();
        step();
        check("hold_alu_res", alu_res, 32'd11);
        check("hold_dst_out", {27'd0, dst_out}, 32'd3);
        memReady = 1;
        step();
        check("release_alu_res", alu_res, 32'd104);
`ifdef ITER_MUL_EN
        exe_cmd = 4'hC; val1 = 6; val2 = 7;
        n = 0;
        while (exe_stall && n < 100) begin n++; step(); end
        check("mul_stall_len", n, 32'd33);
        step();
        check("mul_6x7", alu_res, 32'd42);
        check("mul_wb_en_out", {31'd0, wb_en_out}, 32'd1);
        val1 = 32'hFFFFFFFF; val2 = 2;
        n = 0;
        while (exe_stall && n < 100) begin
            n++;
            memReady = !(n > 3 && n <= 8);
            step();
        end
        memReady = 1;
        check("mul_frozen_stall_len", n, 32'd38);
        step();
        check("mul_wrap", alu_res, 32'hFFFFFFFE);
        val1 = 6; val2 = 7;
        repeat (5) step();
        check("mul_run_stall", {31'd0, exe_stall}, 32'd1);
        rst = 1;
        #1 check("rst_stall", {31'd0, exe_stall}, 32'd0);
        check("rst_alu_res", alu_res, 32'd0);
        exe_cmd = 4'h0;
        step();
        rst = 0;
        step();
        check("post_rst_add", alu_res, 32'd13);
`else
        exe_cmd = 4'hC; val1 = 6; val2 = 7;
        #1 check("mul_no_stall", {31'd0, exe_stall}, 32'd0);
        step();
        check("mul_disabled", alu_res, 32'd0);
        exe_cmd = 4'h0;
        step();
        check("add_after_mul", alu_res, 32'd13);
`endif
        chk_en = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
